// File: rtl/channel_pkg.sv
// -----------------------------------------------------------------------------
// channel_pkg
// Shared definitions for the HLS channel blocks.
//   CHANNEL_WIDTH_DEFAULT : default data word width in bits
//   CHANNEL_DEPTH_DEFAULT : default number of buffered entries
//   ptr_next()            : circular pointer increment, wraps DEPTH-1 -> 0.
//                           Works for any depth, power of two or not.
// -----------------------------------------------------------------------------
package channel_pkg;

  localparam int CHANNEL_WIDTH_DEFAULT = 32;
  localparam int CHANNEL_DEPTH_DEFAULT = 16;

  // Explicit compare-and-wrap instead of relying on natural binary overflow,
  // so non power-of-two depths never index past the last entry.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    if (ptr == depth - 32'd1) begin
      return 32'd0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/channel_fifo_mem.sv
// -----------------------------------------------------------------------------
// channel_fifo_mem
// DEPTH x WIDTH register file backing the channel FIFO. Contents are not
// reset; a slot only becomes observable after it has been written.
// Ports:
//   clk   : rising-edge clock for the write port
//   waddr : write address (0 .. DEPTH-1)
//   wdata : write data
//   wen   : write enable, word stored at the rising edge
//   raddr : read address (0 .. DEPTH-1)
//   rdata : combinational read data for raddr
// -----------------------------------------------------------------------------
module channel_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wen,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/channel_fifo.sv
// -----------------------------------------------------------------------------
// channel_fifo
// Responder end of the HLS channel interface: a circular register-file FIFO
// between a producer kernel (write side) and a consumer kernel (read side).
//
// Handshake: a request is accepted at a rising edge when its valid and the
// matching ready are both high at that edge. Ready is a pure status that
// depends only on registered state (and rst for write_ready), never on the
// same-cycle valid, so initiators may poll it before pulsing valid. A valid
// seen while ready is low is silently dropped; there is no error flag.
//
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   in_data     : word to push
//   write_valid : push request, one word per cycle
//   read_valid  : pop request, one word per cycle
//   out_data    : last popped word, registered (valid the cycle after a pop)
//   read_ready  : FIFO non-empty
//   write_ready : FIFO not full and not in reset
//   count       : current occupancy, 0 .. DEPTH
// -----------------------------------------------------------------------------
module channel_fifo
  import channel_pkg::*;
#(
  parameter  int WIDTH = CHANNEL_WIDTH_DEFAULT,
  parameter  int DEPTH = CHANNEL_DEPTH_DEFAULT,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             write_valid,
  input  logic             read_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             read_ready,
  output logic             write_ready,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out_data;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_rdata;

  // ---------------------------------------------------------------------------
  // Status. Full/empty come from the occupancy counter rather than pointer
  // comparison, which keeps non power-of-two depths trivial.
  // ---------------------------------------------------------------------------
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign read_ready  = !w_empty;
  assign write_ready = !rst && !w_full;

  // Acceptance uses the pre-edge ready values: a full FIFO rejects a push even
  // when a pop frees a slot in the same cycle, and an empty FIFO rejects a pop
  // even when a push arrives in the same cycle (no pass-through, no bypass).
  assign w_push = write_valid && write_ready;
  assign w_pop  = read_valid && read_ready;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  channel_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .wen   (w_push),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // ---------------------------------------------------------------------------
  // Write pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= PW'(ptr_next(32'(r_wr_ptr), DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Read pointer and registered output. out_data holds the last popped word
  // until the next accepted pop; an ignored pop leaves it untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_out_data <= '0;
    end else if (w_pop) begin
      r_rd_ptr   <= PW'(ptr_next(32'(r_rd_ptr), DEPTH));
      r_out_data <= w_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data = r_out_data;
  assign count    = r_count;

endmodule

// File: tb/tb_channel_fifo.sv
module tb_channel_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             write_valid = 1'b0;
  logic             read_valid = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             read_ready;
  logic             write_ready;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  channel_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .write_valid (write_valid),
    .read_valid  (read_valid),
    .out_data    (out_data),
    .read_ready  (read_ready),
    .write_ready (write_ready),
    .count       (count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: behavioural FIFO model
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_out = '0;
  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change 1 time unit after a rising edge; outputs are
  // sampled at that same point, away from the active edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic wv, input logic rv, input logic [WIDTH-1:0] d);
    bit push_ok;
    bit pop_ok;
    write_valid = wv;
    read_valid  = rv;
    in_data     = d;
    @(posedge clk);
    push_ok = wv && !rst && (exp_q.size() < DEPTH);
    pop_ok  = rv && (exp_q.size() > 0);
    if (pop_ok)  exp_out = exp_q.pop_front();
    if (push_ok) exp_q.push_back(d);
    #1;
    write_valid = 1'b0;
    read_valid  = 1'b0;
  endtask

  task automatic assert_reset_midcycle();
    #3;
    rst = 1'b1;
    exp_q.delete();
    exp_out = '0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    total++; if (count !== '0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (read_ready !== 1'b0)  begin bad++; $display("FAIL reset_rr got=%b exp=0", read_ready); end
    total++; if (write_ready !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", write_ready); end
    total++; if (out_data !== '0)  begin bad++; $display("FAIL reset_out got=%h exp=0", out_data); end
    repeat (2) @(posedge clk);
    release_reset();
    total++; if (write_ready !== 1'b1) begin bad++; $display("FAIL release_wr got=%b exp=1", write_ready); end
    @(posedge clk); #1;
    total++; if (count !== '0) begin bad++; $display("FAIL release_count got=%0d exp=0", count); end
    // Populate state, then check the reset clears it without a clock edge.
    drive(1'b1, 1'b0, 32'hA1);
    drive(1'b1, 1'b0, 32'hA2);
    drive(1'b0, 1'b1, '0);
    total++; if (out_data !== 32'hA1) begin bad++; $display("FAIL pre_rst_out got=%h exp=a1", out_data); end
    assert_reset_midcycle();
    total++; if (count !== '0)         begin bad++; $display("FAIL async_count got=%0d exp=0", count); end
    total++; if (out_data !== '0)      begin bad++; $display("FAIL async_out got=%h exp=0", out_data); end
    total++; if (read_ready !== 1'b0)  begin bad++; $display("FAIL async_rr got=%b exp=0", read_ready); end
    total++; if (write_ready !== 1'b0) begin bad++; $display("FAIL async_wr got=%b exp=0", write_ready); end
    release_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    drive(1'b1, 1'b0, 32'h0000002A);
    total++; if (read_ready !== 1'b1) begin bad++; $display("FAIL single_rr got=%b exp=1", read_ready); end
    total++; if (count !== CW'(1))    begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    drive(1'b0, 1'b1, '0);
    total++; if (out_data !== 32'h2A) begin bad++; $display("FAIL single_out got=%h exp=2a", out_data); end
    total++; if (count !== '0)        begin bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
    total++; if (read_ready !== 1'b0) begin bad++; $display("FAIL single_rr0 got=%b exp=0", read_ready); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0);
      total++; if (out_data !== 32'h2A) begin bad++; $display("FAIL single_hold%0d got=%h exp=2a", i, out_data); end
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, 1'b0, WIDTH'(i));
    total++; if (write_ready !== 1'b0)  begin bad++; $display("FAIL fill_wr got=%b exp=0", write_ready); end
    total++; if (count !== CW'(DEPTH))  begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH); end
    drive(1'b1, 1'b0, 32'd99);
    total++; if (count !== CW'(DEPTH))  begin bad++; $display("FAIL overflow_count got=%0d exp=%0d", count, DEPTH); end
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 1'b1, '0);
      total++; if (out_data !== WIDTH'(i)) begin bad++; $display("FAIL fill_pop%0d got=%0d exp=%0d", i, out_data, i); end
    end
    total++; if (count !== '0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
    for (int i = 17; i <= 20; i++) drive(1'b1, 1'b0, WIDTH'(i));
    for (int i = 17; i <= 20; i++) begin
      drive(1'b0, 1'b1, '0);
      total++; if (out_data !== WIDTH'(i)) begin bad++; $display("FAIL wrap_pop%0d got=%0d exp=%0d", i, out_data, i); end
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, 1'b0, WIDTH'(i));
    drive(1'b1, 1'b1, 32'hDEAD);
    total++; if (out_data !== 32'd1)       begin bad++; $display("FAIL fullpp_out got=%h exp=1", out_data); end
    total++; if (count !== CW'(DEPTH - 1)) begin bad++; $display("FAIL fullpp_count got=%0d exp=%0d", count, DEPTH - 1); end
    for (int i = 2; i <= DEPTH; i++) begin
      drive(1'b0, 1'b1, '0);
      total++; if (out_data !== WIDTH'(i)) begin bad++; $display("FAIL fullpp_pop%0d got=%h exp=%0d", i, out_data, i); end
    end
    total++; if (read_ready !== 1'b0) begin bad++; $display("FAIL fullpp_empty got=%b exp=0", read_ready); end
  endtask

  task automatic test_empty_push_pop();
    logic [WIDTH-1:0] prev;
    prev = out_data;
    drive(1'b1, 1'b1, 32'd7);
    total++; if (out_data !== prev)   begin bad++; $display("FAIL emptypp_out got=%h exp=%h", out_data, prev); end
    total++; if (count !== CW'(1))    begin bad++; $display("FAIL emptypp_count got=%0d exp=1", count); end
    drive(1'b0, 1'b1, '0);
    total++; if (out_data !== 32'd7)  begin bad++; $display("FAIL emptypp_pop got=%h exp=7", out_data); end
  endtask

  task automatic test_initiator();
    logic [WIDTH-1:0] vals[4];
    int sum;
    vals[0] = 3; vals[1] = 5; vals[2] = 7; vals[3] = 9;
    sum = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, vals[i]);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 20 && !read_ready; k++) drive(1'b0, 1'b0, '0);
      total++;
      if (!read_ready) begin
        bad++; $display("FAIL init_poll%0d got=rr0 exp=rr1 (timeout)", i);
      end else begin
        drive(1'b0, 1'b1, '0);
        if (out_data !== vals[i]) begin bad++; $display("FAIL init_pop%0d got=%0d exp=%0d", i, out_data, vals[i]); end
        sum += int'(out_data);
      end
    end
    total++; if (sum != 24) begin bad++; $display("FAIL init_sum got=%0d exp=24", sum); end
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, WIDTH'(i * 100));
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, '0);
    total++; if (out_data !== 32'd200) begin bad++; $display("FAIL midrst_pop got=%0d exp=200", out_data); end
    assert_reset_midcycle();
    total++; if (count !== '0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
    release_reset();
    total++; if (write_ready !== 1'b1 || count !== '0) begin
      bad++; $display("FAIL midrst_release got=wr%b/cnt%0d exp=wr1/cnt0", write_ready, count);
    end
    drive(1'b1, 1'b0, 32'd11);
    drive(1'b0, 1'b1, '0);
    total++; if (out_data !== 32'd11) begin bad++; $display("FAIL midrst_after got=%0d exp=11", out_data); end
  endtask

  task automatic test_random();
    logic wv;
    logic rv;
    for (int i = 0; i < 600; i++) begin
      // Bias toward pushes in the first half and pops in the second so both
      // full and empty corners are visited.
      wv = ($urandom_range(0, 99) < ((i < 300) ? 70 : 35));
      rv = ($urandom_range(0, 99) < ((i < 300) ? 35 : 70));
      drive(wv, rv, WIDTH'($urandom));
      total++;
      if (out_data !== exp_out || count !== CW'(exp_q.size()) ||
          read_ready !== (exp_q.size() != 0) || write_ready !== (exp_q.size() != DEPTH)) begin
        bad++;
        $display("FAIL random%0d got=out%h/cnt%0d/rr%b/wr%b exp=out%h/cnt%0d", i, out_data, count,
                 read_ready, write_ready, exp_out, exp_q.size());
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_full_push_pop();
    test_empty_push_pop();
    test_initiator();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
